vram_access_scheduler: RTL and testbench

- Shares the single external SPI VRAM controller between two requesters: the video line prefetch and the Hack CPU screen-memory port.
- Sits between video_generator_640x480 (hpos/vpos timing), the CPU bus and the VRAM SPI controller; steers read data into a double-banked line buffer.
- Video fetch has priority. Arbitration is non-preemptive: a transaction, once accepted by the memory controller, always completes.

---
 rtl/vram_sched_pkg.sv | 14 +
 rtl/vram_line_trigger.sv | 17 +
 rtl/vram_access_scheduler.sv | 146 ++++++++++++++
 tb/tb_vram_access_scheduler.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_sched_pkg.sv
// Shared constants for the VRAM access scheduler: FSM state codes and field widths.
package vram_sched_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_F_CMD  = 3'd1;
  localparam logic [2:0] ST_F_DATA = 3'd2;
  localparam logic [2:0] ST_C_CMD  = 3'd3;
  localparam logic [2:0] ST_C_WAIT = 3'd4;

  localparam int MEM_LEN_W          = 6;
  localparam int WORDS_PER_LINE_DEF = 32;
  localparam int WIDX_W             = $clog2(WORDS_PER_LINE_DEF);

endpackage

// File: rtl/vram_line_trigger.sv
// Prefetch trigger: fires at start of hblank when the following line is VRAM-backed.
// Purely combinational; the scheduler registers whatever it needs.
module vram_line_trigger #(
  parameter int H_ACTIVE     = 640,
  parameter int V_TOTAL      = 525,
  parameter int SCREEN_LINES = 256
) (
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  output logic       trig,
  output logic [9:0] next_line
);

  assign next_line = (vpos == 10'(V_TOTAL - 1)) ? 10'd0 : vpos + 10'd1;
  assign trig      = (hpos == 10'(H_ACTIVE)) && (next_line < 10'(SCREEN_LINES));

endmodule

// File: rtl/vram_access_scheduler.sv
// Arbitrates the single VRAM controller between video line prefetch (priority) and CPU.
// Non-preemptive; commands hold valid with stable fields until mem_cmd_ready.
module vram_access_scheduler
  import vram_sched_pkg::*;
#(
  parameter int H_ACTIVE       = 640,
  parameter int V_TOTAL        = 525,
  parameter int SCREEN_LINES   = 256,
  parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEF,
  parameter int ADDR_W         = 13
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [9:0]           hpos,
  input  logic [9:0]           vpos,
  input  logic                 cpu_req,
  input  logic                 cpu_we,
  input  logic [ADDR_W-1:0]    cpu_addr,
  input  logic [15:0]          cpu_wdata,
  output logic                 cpu_ack,
  output logic [15:0]          cpu_rdata,
  output logic                 mem_cmd_valid,
  input  logic                 mem_cmd_ready,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [MEM_LEN_W-1:0] mem_len,
  output logic [15:0]          mem_wdata,
  input  logic                 mem_rvalid,
  input  logic [15:0]          mem_rdata,
  input  logic                 mem_done,
  output logic                 lb_we,
  output logic [WIDX_W:0]      lb_waddr,
  output logic [15:0]          lb_wdata,
  output logic                 fetch_overrun
);

  logic [2:0]        state;
  logic              fetch_pending;
  logic [9:0]        fetch_line;
  logic [WIDX_W:0]   wcnt;
  logic              trig;
  logic [9:0]        next_line;
  logic              fetch_busy;
  logic              trig_drop;
  logic              trig_take;
  logic              wcnt_full;
  logic [9:0]        start_line;
  logic [ADDR_W-1:0] fetch_addr;

  vram_line_trigger #(
    .H_ACTIVE    (H_ACTIVE),
    .V_TOTAL     (V_TOTAL),
    .SCREEN_LINES(SCREEN_LINES)
  ) u_trigger (
    .hpos     (hpos),
    .vpos     (vpos),
    .trig     (trig),
    .next_line(next_line)
  );

  assign fetch_busy = (state == ST_F_CMD) || (state == ST_F_DATA);
  assign trig_drop  = trig && (fetch_pending || fetch_busy);
  assign trig_take  = trig && !trig_drop;
  assign wcnt_full  = (wcnt == (WIDX_W + 1)'(WORDS_PER_LINE));

  // A trigger landing in the IDLE cycle itself is served directly, so a
  // same-cycle cpu_req loses to it.
  assign start_line = fetch_pending ? fetch_line : next_line;
  assign fetch_addr = ADDR_W'({start_line, {WIDX_W{1'b0}}});

  assign lb_we    = (state == ST_F_DATA) && mem_rvalid && !wcnt_full;
  assign lb_waddr = lb_we ? {fetch_line[0], wcnt[WIDX_W-1:0]} : '0;
  assign lb_wdata = lb_we ? mem_rdata : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      fetch_pending <= 1'b0;
      fetch_line    <= '0;
      wcnt          <= '0;
      cpu_ack       <= 1'b0;
      cpu_rdata     <= '0;
      mem_cmd_valid <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_len       <= '0;
      mem_wdata     <= '0;
      fetch_overrun <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      if (trig_drop) fetch_overrun <= 1'b1;
      if (trig_take) begin
        fetch_pending <= 1'b1;
        fetch_line    <= next_line;
      end

      case (state)
        ST_IDLE: begin
          if (fetch_pending || trig) begin
            state         <= ST_F_CMD;
            mem_cmd_valid <= 1'b1;
            mem_we        <= 1'b0;
            mem_addr      <= fetch_addr;
            mem_len       <= MEM_LEN_W'(WORDS_PER_LINE);
            mem_wdata     <= '0;
          end else if (cpu_req && !cpu_ack) begin
            // cpu_ack high means this IDLE cycle still sees the request just served.
            state         <= ST_C_CMD;
            mem_cmd_valid <= 1'b1;
            mem_we        <= cpu_we;
            mem_addr      <= cpu_addr;
            mem_len       <= MEM_LEN_W'(1);
            mem_wdata     <= cpu_wdata;
          end
        end
        ST_F_CMD: begin
          if (mem_cmd_ready) begin
            mem_cmd_valid <= 1'b0;
            fetch_pending <= 1'b0;
            wcnt          <= '0;
            state         <= ST_F_DATA;
          end
        end
        ST_F_DATA: begin
          if (mem_rvalid && !wcnt_full) wcnt <= wcnt + 1'b1;
          if (mem_done) state <= ST_IDLE;
        end
        ST_C_CMD: begin
          if (mem_cmd_ready) begin
            mem_cmd_valid <= 1'b0;
            state         <= ST_C_WAIT;
          end
        end
        ST_C_WAIT: begin
          if (mem_rvalid && !mem_we) cpu_rdata <= mem_rdata;
          if (mem_done) begin
            cpu_ack <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_access_scheduler.sv
// Randomized bench: behavioural VRAM controller plus a word-array memory model.
module tb_vram_access_scheduler;

  logic        clk = 0;
  logic        reset = 1;
  logic [9:0]  hpos = 0, vpos = 0;
  logic        cpu_req = 0, cpu_we = 0;
  logic [12:0] cpu_addr = 0;
  logic [15:0] cpu_wdata = 0;
  logic        cpu_ack;
  logic [15:0] cpu_rdata;
  logic        mem_cmd_valid, mem_cmd_ready = 0, mem_we;
  logic [12:0] mem_addr;
  logic [5:0]  mem_len;
  logic [15:0] mem_wdata;
  logic        mem_rvalid = 0, mem_done = 0;
  logic [15:0] mem_rdata = 0;
  logic        lb_we;
  logic [5:0]  lb_waddr;
  logic [15:0] lb_wdata;
  logic        fetch_overrun;

  vram_access_scheduler dut (
    .clk(clk), .reset(reset), .hpos(hpos), .vpos(vpos),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_len(mem_len), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_done(mem_done),
    .lb_we(lb_we), .lb_waddr(lb_waddr), .lb_wdata(lb_wdata), .fetch_overrun(fetch_overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0, cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Memory contents: vram is what the controller serves, model_mem is the bench's expectation.
  logic [15:0] vram[8192];
  logic [15:0] model_mem[8192];

  typedef struct packed {
    logic        we;
    logic [12:0] addr;
    logic [5:0]  len;
    logic [15:0] wdata;
  } cmd_t;

  cmd_t cmd_q[$];
  int   cmd_cyc[$], done_q[$], rise_q[$];
  logic [15:0] lb_shadow[64];
  int   lb_cnt = 0;

  // Controller knobs
  int rdy_max = 0, wdone_delay = 2, extra_rv = 0;
  bit hold_ready = 0;
  int resp_phase = 0;

  initial begin : responder
    int rd_left, extra_left, k, dly;
    cmd_t acc;
    forever begin
      @(posedge clk); #1;
      mem_rvalid = 0;
      mem_done   = 0;
      if (reset) begin
        resp_phase = 0;
        mem_cmd_ready = 0;
      end else if (mem_cmd_ready) begin
        mem_cmd_ready = 0;
        rd_left = int'(acc.len); k = 0; dly = wdone_delay;
        extra_left = (acc.len > 1) ? extra_rv : 0;
        if (acc.we) begin
          vram[acc.addr] = acc.wdata;
          resp_phase = 2;
        end else resp_phase = 1;
      end else if (resp_phase == 0) begin
        if (mem_cmd_valid && !hold_ready && $urandom_range(0, rdy_max) == 0) begin
          mem_cmd_ready = 1;
          acc = '{mem_we, mem_addr, mem_len, mem_wdata};
        end
      end else if (resp_phase == 1) begin
        if (rd_left > 0) begin
          if ($urandom_range(0, 3) != 0) begin
            mem_rvalid = 1;
            mem_rdata  = vram[(int'(acc.addr) + k) % 8192];
            k++; rd_left--;
          end
        end else if (extra_left > 0) begin
          mem_rvalid = 1;
          mem_rdata  = 16'($urandom);
          extra_left--;
        end else begin
          mem_done = 1;
          resp_phase = 0;
        end
      end else begin
        if (dly > 0) dly--;
        else begin
          mem_done = 1;
          resp_phase = 0;
        end
      end
    end
  end

  logic prev_valid = 0, prev_acc = 0;
  cmd_t prev_cmd;
  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 0;
      prev_acc   = 0;
    end else begin
      if (lb_we) begin
        lb_shadow[lb_waddr] = lb_wdata;
        lb_cnt++;
      end
      if (prev_valid && !prev_acc)
        check("cmd_hold", {mem_cmd_valid, mem_we, mem_addr, mem_len, mem_wdata}, {1'b1, prev_cmd});
      if (mem_cmd_valid && !prev_valid) rise_q.push_back(cyc);
      if (mem_cmd_valid && mem_cmd_ready) begin
        cmd_q.push_back('{mem_we, mem_addr, mem_len, mem_wdata});
        cmd_cyc.push_back(cyc);
      end
      if (mem_done) done_q.push_back(cyc);
      prev_valid = mem_cmd_valid;
      prev_acc   = mem_cmd_valid && mem_cmd_ready;
      prev_cmd   = '{mem_we, mem_addr, mem_len, mem_wdata};
    end
  end

  task automatic pulse_trig(input int v);
    @(posedge clk); #1;
    hpos = 10'd640;
    vpos = 10'(v);
    @(posedge clk); #1;
    hpos = 10'($urandom_range(0, 639));
  endtask

  task automatic wait_quiet(input int budget);
    int q = 0;
    for (int t = 0; t < budget && q < 4; t++) begin
      @(negedge clk);
      if (!mem_cmd_valid && !mem_cmd_ready && resp_phase == 0) q++;
      else q = 0;
    end
    check("quiet", q, 4);
  endtask

  function automatic int line_after(input int v);
    return (v == 524) ? 0 : v + 1;
  endfunction

  task automatic clear_lb();
    for (int i = 0; i < 64; i++) lb_shadow[i] = 'x;
    lb_cnt = 0;
  endtask

  task automatic check_fetch(input int nl, input int idx);
    check("fetch_cmd", {cmd_q[idx].we, cmd_q[idx].addr, cmd_q[idx].len},
          {1'b0, 13'(nl * 32), 6'd32});
    check("lb_cnt", lb_cnt, 32);
    for (int i = 0; i < 32; i++)
      check("lb_word", lb_shadow[(nl % 2) * 32 + i], model_mem[nl * 32 + i]);
  endtask

  task automatic do_fetch(input int v);
    int n0 = cmd_q.size();
    int nl = line_after(v);
    clear_lb();
    pulse_trig(v);
    wait_quiet(400);
    if (nl < 256) begin
      check("fetch_ncmd", cmd_q.size() - n0, 1);
      check_fetch(nl, cmd_q.size() - 1);
    end else begin
      check("nofetch_ncmd", cmd_q.size() - n0, 0);
      check("nofetch_lb", lb_cnt, 0);
    end
  endtask

  task automatic cpu_access(input bit we, input logic [12:0] a, input logic [15:0] d);
    bit got = 0;
    @(posedge clk); #1;
    cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    for (int t = 0; t < 400 && !got; t++) begin
      @(negedge clk);
      if (cpu_ack) got = 1;
    end
    check("cpu_ack_seen", got, 1);
    if (got) begin
      check("cpu_cmd", {cmd_q[$].we, cmd_q[$].addr, cmd_q[$].len}, {we, a, 6'd1});
      if (we) begin
        check("cpu_wdata", cmd_q[$].wdata, d);
        model_mem[a] = d;
      end else check("cpu_rdata", cpu_rdata, model_mem[a]);
    end
    @(posedge clk); #1;
    cpu_req = 0;
    @(negedge clk);
    check("cpu_ack_pulse", cpu_ack, 0);
  endtask

  initial begin : watchdog
    #600000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int n0, nl, v;
    bit seen;
    for (int i = 0; i < 8192; i++) begin
      vram[i] = 16'($urandom);
      model_mem[i] = vram[i];
    end
    for (int i = 0; i < 32; i++) begin
      vram[320 + i] = 16'h1000 + 16'(i);
      model_mem[320 + i] = vram[320 + i];
    end
    vram[13'h1ABC] = 16'hBEEF;
    model_mem[13'h1ABC] = 16'hBEEF;

    #1;
    check("rst_out_a", {mem_cmd_valid, cpu_ack, cpu_rdata, lb_we, lb_waddr, lb_wdata}, 0);
    check("rst_out_b", {mem_we, mem_addr, mem_len, mem_wdata, fetch_overrun}, 0);
    repeat (3) @(posedge clk);
    #1 reset = 0;

    // Directed: single fetch, frame wrap, unbacked line, CPU read
    do_fetch(9);
    do_fetch(524);
    do_fetch(255);
    cpu_access(0, 13'h1ABC, 16'h0);

    // Collision: trigger and cpu_req in the same cycle
    clear_lb();
    rdy_max = 2;
    fork
      cpu_access(0, 13'h0100, 16'h1234);
      pulse_trig(99);
    join
    wait_quiet(400);
    n0 = cmd_q.size();
    check("coll_order", cmd_q[n0 - 1].len, 1);
    check_fetch(100, n0 - 2);
    check("coll_cpu_after_fetch", cmd_cyc[n0 - 1] > done_q[n0 - 2], 1);

    // Trigger while a CPU write is waiting for mem_done
    clear_lb();
    wdone_delay = 20;
    n0 = cmd_q.size();
    fork
      cpu_access(1, 13'h1F00, 16'hA5A5);
      begin
        seen = 0;
        for (int t = 0; t < 200 && !seen; t++) begin
          @(negedge clk);
          if (cmd_q.size() > n0) seen = 1;
        end
        check("inflight_cmd_seen", seen, 1);
        repeat (3) @(posedge clk);
        pulse_trig(49);
      end
    join
    wait_quiet(400);
    wdone_delay = 2;
    check("inflight_ncmd", cmd_q.size() - n0, 2);
    check_fetch(50, n0 + 1);
    check("inflight_gap", rise_q[$] - done_q[n0], 2);
    check("inflight_no_overrun", fetch_overrun, 0);

    // Randomized mix of fetches and CPU accesses
    for (int it = 0; it < 14; it++) begin
      rdy_max  = $urandom_range(0, 3);
      extra_rv = $urandom_range(0, 2);
      case ($urandom_range(0, 2))
        0: begin
          v = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 254) : $urandom_range(0, 524);
          do_fetch(v);
        end
        1: cpu_access(1, 13'($urandom), 16'($urandom));
        default: cpu_access(0, 13'($urandom_range(0, 8191)), 16'($urandom));
      endcase
    end
    extra_rv = 0;
    check("no_overrun_yet", fetch_overrun, 0);

    // Overrun: second trigger while the first fetch cannot get its command accepted
    clear_lb();
    hold_ready = 1;
    n0 = cmd_q.size();
    pulse_trig(20);
    repeat (10) @(posedge clk);
    pulse_trig(30);
    @(negedge clk);
    check("overrun_set", fetch_overrun, 1);
    hold_ready = 0;
    wait_quiet(400);
    check("overrun_ncmd", cmd_q.size() - n0, 1);
    check_fetch(21, cmd_q.size() - 1);
    check("overrun_sticky", fetch_overrun, 1);

    // Asynchronous reset in the middle of a line burst
    clear_lb();
    pulse_trig(40);
    for (int t = 0; t < 300 && lb_cnt < 5; t++) @(negedge clk);
    check("rst_reach_fdata", lb_cnt >= 5, 1);
    @(posedge clk); #2;
    reset = 1;
    #1;
    check("midrst_out_a", {mem_cmd_valid, cpu_ack, cpu_rdata, lb_we, lb_waddr, lb_wdata}, 0);
    check("midrst_out_b", {mem_we, mem_addr, mem_len, mem_wdata, fetch_overrun}, 0);
    repeat (3) @(posedge clk);
    #1 reset = 0;
    repeat (5) @(negedge clk);
    check("post_rst_idle", {mem_cmd_valid, fetch_overrun}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
